fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
Read-side controller for a fifo_buffer instance. On a start command it pops exactly burst_len words from the FIFO and absorbs the FIFO's one-cycle registered read latency. It presents the words on a valid/ready stream with a last-beat marker. A 2-entry skid buffer sustains one word per cycle under continuous m_ready and never loses or duplicates data under backpressure.

Parameters:
WIDTH, 32, data word width (must match the attached FIFO)
LENGTH, 32, maximum burst length in words; LW = $clog2(LENGTH)+1 bits for length/counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  burst request; sampled only in IDLE
burst_len  input  LW  words to read; captured on accepted start; valid range 0..LENGTH
busy  output  1  high from accepted start until done pulse (inclusive)
done  output  1  one-cycle pulse at burst completion
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO pop strobe
fifo_rd_data  input  WIDTH  FIFO read data, valid the cycle after fifo_rd_en
m_valid  output  1  output word valid
m_ready  input  1  downstream accepts word
m_data  output  WIDTH  output word
m_last  output  1  high with final word of burst

Behaviour:
- Reset: asynchronous, active-high. All outputs 0, state IDLE, counters 0, skid buffer empty, in-flight flag 0. Reset mid-burst discards all buffered/in-flight data; no done pulse.
- States: IDLE, READ, FLUSH, DONE.
- IDLE: busy=0. start=1 captures burst_len into len_q and clears issued/sent counters.
  - burst_len=0: go to DONE.
  - Otherwise: go to READ.
- READ: busy=1. fifo_rd_en=1 iff all three hold:
  - !fifo_empty
  - issued < len_q
  - (occupancy + inflight - pop) < 2, where pop = m_valid & m_ready this cycle.
  - Each strobe increments issued and sets inflight for the next cycle.
  - When issued reaches len_q, go to FLUSH.
- FLUSH: no reads. Wait until sent == len_q with buffer empty and inflight=0, then go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. A new start is accepted no earlier than the cycle after done.
- start is ignored outside IDLE; burst_len changes after capture have no effect.
- Capture: when inflight=1, fifo_rd_data is written into the skid buffer that cycle, regardless of m_ready.
- Skid buffer: 2-entry FIFO-ordered. m_valid = occupancy != 0. m_data = head entry. Simultaneous capture and pop keeps occupancy unchanged with correct ordering.
- m_last = m_valid & (sent == len_q-1). sent increments on each pop.
- Throughput: with fifo_empty=0 and m_ready=1 continuously, first m_valid appears 2 cycles after start (start -> rd_en -> capture -> valid). After that, one word per cycle with no bubbles.
- Backpressure: m_valid/m_data hold stable while m_ready=0. Reads stall once occupancy + inflight = 2.
- FIFO empty mid-burst: reads pause and resume when not empty; output order is preserved.
- Counter widths are LW bits. No wrap is possible since len_q <= LENGTH.
- The block never asserts fifo_rd_en when fifo_empty=1 or after len_q reads.

Test Plan:
- Reset mid-operation: burst_len=8, assert rst after 3 words -> all outputs 0 immediately (asynchronous); no done pulse. Next start with burst_len=2 reads the next 2 FIFO words correctly.
- Basic burst: FIFO preloaded 0x10..0x17, burst_len=4, m_ready=1 -> fifo_rd_en high 4 consecutive cycles starting the cycle after start. m_data 0x10,0x11,0x12,0x13 on consecutive cycles, m_last on 0x13, done 1 cycle after last pop.
- Backpressure: burst_len=6, m_ready toggles 1,0,0,1,0,1... -> exactly 6 pops in order 0x10..0x15. Occupancy+inflight never exceeds 2. m_data stable whenever m_valid=1 and m_ready=0.
- Starvation: FIFO holds 2 words, burst_len=5, 3 more words pushed 10 cycles later -> reads pause while fifo_empty=1, busy stays high, all 5 words emitted in order, done after the 5th.
- Zero/full length: burst_len=0 -> done pulse in the cycle after start, no fifo_rd_en, no m_valid. burst_len=LENGTH=32 with continuous data -> 32 beats, m_last only on beat 32.
- start ignored while busy: start pulsed during a burst_len=4 run -> no effect on len_q or counters; second start after done accepted normally.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for a registered-output FIFO: pops a fixed number of
// words, absorbs the one-cycle read latency and streams them through a 2-entry skid buffer.
module fifo_burst_reader #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LENGTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(LENGTH):0]    burst_len,
  output logic                       busy,
  output logic                       done,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [WIDTH-1:0]           fifo_rd_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic                       m_last
);

  localparam int unsigned LW = $clog2(LENGTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     issued_q;
  logic [LW-1:0]     sent_q;
  logic              inflight_q;
  logic [1:0]        occ_q;
  logic [WIDTH-1:0]  buf0_q, buf1_q;

  logic              rd_en;
  logic              pop;
  logic              flush_done;
  logic [2:0]        pending;

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf0_q;
  assign m_last     = m_valid & (sent_q == len_q - LW'(1));
  assign pop        = m_valid & m_ready;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign fifo_rd_en = rd_en;

  // Words owned by the skid buffer after this cycle, before any new read is issued
  assign pending    = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

  // The final pop can finish the burst directly, so done follows the last beat by one cycle
  assign flush_done = (sent_q == len_q) | (pop & m_last);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and read strobe
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (burst_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        rd_en = !fifo_empty && (issued_q < len_q) && (pending < 3'd2);
        if (rd_en && (issued_q == len_q - LW'(1))) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Burst length capture, issue/send counters and read-latency tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start) begin
        len_q    <= burst_len;
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (rd_en) begin
          issued_q <= issued_q + LW'(1);
        end
        if (pop) begin
          sent_q <= sent_q + LW'(1);
        end
      end
      inflight_q <= rd_en;
    end
  end

  // Two-entry skid buffer; buf0_q is always the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      case ({inflight_q, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            buf0_q <= fifo_rd_data;
          end else begin
            buf1_q <= fifo_rd_data;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          buf0_q <= buf1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_q <= fifo_rd_data;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= fifo_rd_data;
          end
        end
        default: begin
          occ_q <= occ_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural registered-output FIFO
// and a negedge stream monitor.
module tb_fifo_burst_reader;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned LENGTH = 32;
  localparam int unsigned LW     = $clog2(LENGTH) + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LW-1:0]     burst_len;
  logic              busy;
  logic              done;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [WIDTH-1:0]  fifo_rd_data = '0;
  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  m_data;
  logic              m_last;

  int nvec = 0;
  int nerr = 0;

  fifo_burst_reader #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .burst_len    (burst_len),
    .busy         (busy),
    .done         (done),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: data appears one cycle after the pop strobe
  logic [31:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          cyc    = 0;
  logic        rd_req = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_req) begin
      fifo_rd_data <= mem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Stream monitor, sampled mid-cycle
  logic [31:0] rx_data [$];
  bit          rx_last [$];
  int          rx_cyc  [$];
  int          rd_cyc  [$];
  int          done_cyc[$];
  int          issued_tot = 0;
  int          popped_tot = 0;
  int          viol_empty = 0;
  int          viol_occ = 0;
  int          viol_stable = 0;
  int          valid_cnt = 0;
  logic        hold = 1'b0;
  logic [31:0] hold_data = '0;

  always @(negedge clk) begin
    rd_req <= fifo_rd_en && !rst;
    if (rst) begin
      issued_tot <= 0;
      popped_tot <= 0;
      hold       <= 1'b0;
    end else begin
      if (fifo_rd_en) begin
        rd_cyc.push_back(cyc);
        if (fifo_empty) viol_empty <= viol_empty + 1;
      end
      if (m_valid) valid_cnt <= valid_cnt + 1;
      if (m_valid && m_ready) begin
        rx_data.push_back(m_data);
        rx_last.push_back(m_last);
        rx_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      if (issued_tot - popped_tot > 2) viol_occ <= viol_occ + 1;
      issued_tot <= issued_tot + (fifo_rd_en ? 1 : 0);
      popped_tot <= popped_tot + ((m_valid && m_ready) ? 1 : 0);
      if (hold && (!m_valid || m_data !== hold_data)) viol_stable <= viol_stable + 1;
      hold      <= m_valid && !m_ready;
      hold_data <= m_data;
    end
  end

  task automatic push(input logic [31:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic launch(input int len, output int s);
    @(posedge clk); #1;
    start     = 1'b1;
    burst_len = LW'(len);
    s         = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
    burst_len = LW'(21);
  endtask

  task automatic wait_done(input int d0, input int maxc);
    for (int i = 0; i < maxc && done_cyc.size() == d0; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b exp 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b exp 0", done); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    nvec++; if (m_last !== 1'b0) begin nerr++; $display("FAIL reset_m_last got %b exp 0", m_last); end
    nvec++; if (fifo_rd_en !== 1'b0) begin nerr++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
    nvec++; if (m_data !== 32'd0) begin nerr++; $display("FAIL reset_m_data got %h exp 0", m_data); end
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int s, r0, d0, q0;
    for (int i = 0; i < 4; i++) push(32'h10 + i);
    m_ready = 1'b1;
    r0 = rx_data.size(); d0 = done_cyc.size(); q0 = rd_cyc.size();
    launch(4, s);
    wait_done(d0, 40);
    nvec++; if (done_cyc.size() != d0 + 1) begin nerr++; $display("FAIL basic_done_count got %0d exp %0d", done_cyc.size() - d0, 1); end
    nvec++; if (rd_cyc.size() - q0 != 4) begin nerr++; $display("FAIL basic_rd_count got %0d exp 4", rd_cyc.size() - q0); end
    nvec++; if (rx_data.size() - r0 != 4) begin nerr++; $display("FAIL basic_beat_count got %0d exp 4", rx_data.size() - r0); end
    for (int i = 0; i < 4 && q0 + i < rd_cyc.size(); i++) begin
      nvec++; if (rd_cyc[q0+i] != s + 1 + i) begin nerr++; $display("FAIL basic_rd_cycle[%0d] got %0d exp %0d", i, rd_cyc[q0+i] - s, 1 + i); end
    end
    for (int i = 0; i < 4 && r0 + i < rx_data.size(); i++) begin
      nvec++; if (rx_data[r0+i] !== 32'h10 + i) begin nerr++; $display("FAIL basic_data[%0d] got %h exp %h", i, rx_data[r0+i], 32'h10 + i); end
      nvec++; if (rx_cyc[r0+i] != s + 3 + i) begin nerr++; $display("FAIL basic_beat_cycle[%0d] got %0d exp %0d", i, rx_cyc[r0+i] - s, 3 + i); end
      nvec++; if (rx_last[r0+i] != (i == 3)) begin nerr++; $display("FAIL basic_last[%0d] got %b exp %b", i, rx_last[r0+i], (i == 3)); end
    end
    if (done_cyc.size() > d0) begin
      nvec++; if (done_cyc[d0] != s + 7) begin nerr++; $display("FAIL basic_done_cycle got %0d exp %0d", done_cyc[d0] - s, 7); end
    end
  endtask

  task automatic test_backpressure();
    int s, r0, d0, n;
    int vo, vs;
    bit bp [0:11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) push(32'h20 + i);
    r0 = rx_data.size(); d0 = done_cyc.size(); vo = viol_occ; vs = viol_stable;
    launch(6, s);
    for (int i = 0; i < 100 && done_cyc.size() == d0; i++) begin
      m_ready = bp[(cyc - s) % 12];
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    n = rx_data.size() - r0;
    nvec++; if (done_cyc.size() != d0 + 1) begin nerr++; $display("FAIL bp_done_count got %0d exp 1", done_cyc.size() - d0); end
    nvec++; if (n != 6) begin nerr++; $display("FAIL bp_beat_count got %0d exp 6", n); end
    for (int i = 0; i < 6 && r0 + i < rx_data.size(); i++) begin
      nvec++; if (rx_data[r0+i] !== 32'h20 + i) begin nerr++; $display("FAIL bp_data[%0d] got %h exp %h", i, rx_data[r0+i], 32'h20 + i); end
      nvec++; if (rx_last[r0+i] != (i == 5)) begin nerr++; $display("FAIL bp_last[%0d] got %b exp %b", i, rx_last[r0+i], (i == 5)); end
    end
    nvec++; if (viol_occ != vo) begin nerr++; $display("FAIL bp_occupancy got %0d overflows exp 0", viol_occ - vo); end
    nvec++; if (viol_stable != vs) begin nerr++; $display("FAIL bp_hold_stable got %0d changes exp 0", viol_stable - vs); end
    if (done_cyc.size() > d0 && n > 0) begin
      nvec++; if (done_cyc[d0] != rx_cyc[rx_cyc.size()-1] + 1) begin nerr++; $display("FAIL bp_done_after_last got %0d exp %0d", done_cyc[d0], rx_cyc[rx_cyc.size()-1] + 1); end
    end
  endtask

  task automatic test_starvation();
    int s, r0, d0, q0, busy_drop, ve;
    for (int i = 0; i < 2; i++) push(32'h30 + i);
    r0 = rx_data.size(); d0 = done_cyc.size(); q0 = rd_cyc.size(); ve = viol_empty;
    busy_drop = 0;
    launch(5, s);
    for (int i = 0; i < 80 && done_cyc.size() == d0; i++) begin
      @(negedge clk);
      if (!busy && done_cyc.size() == d0) busy_drop++;
      @(posedge clk); #1;
      if (cyc == s + 10) for (int k = 2; k < 5; k++) push(32'h30 + k);
    end
    nvec++; if (done_cyc.size() != d0 + 1) begin nerr++; $display("FAIL starve_done_count got %0d exp 1", done_cyc.size() - d0); end
    nvec++; if (busy_drop != 0) begin nerr++; $display("FAIL starve_busy_drop got %0d exp 0", busy_drop); end
    nvec++; if (viol_empty != ve) begin nerr++; $display("FAIL starve_rd_when_empty got %0d exp 0", viol_empty - ve); end
    nvec++; if (rd_cyc.size() - q0 != 5) begin nerr++; $display("FAIL starve_rd_count got %0d exp 5", rd_cyc.size() - q0); end
    if (rd_cyc.size() - q0 >= 3) begin
      nvec++; if (rd_cyc[q0+1] != s + 2) begin nerr++; $display("FAIL starve_rd2_cycle got %0d exp 2", rd_cyc[q0+1] - s); end
      nvec++; if (rd_cyc[q0+2] != s + 10) begin nerr++; $display("FAIL starve_resume_cycle got %0d exp 10", rd_cyc[q0+2] - s); end
    end
    nvec++; if (rx_data.size() - r0 != 5) begin nerr++; $display("FAIL starve_beat_count got %0d exp 5", rx_data.size() - r0); end
    for (int i = 0; i < 5 && r0 + i < rx_data.size(); i++) begin
      nvec++; if (rx_data[r0+i] !== 32'h30 + i) begin nerr++; $display("FAIL starve_data[%0d] got %h exp %h", i, rx_data[r0+i], 32'h30 + i); end
    end
    if (done_cyc.size() > d0 && rx_data.size() > r0) begin
      nvec++; if (done_cyc[d0] != rx_cyc[rx_cyc.size()-1] + 1) begin nerr++; $display("FAIL starve_done_after_last got %0d exp %0d", done_cyc[d0], rx_cyc[rx_cyc.size()-1] + 1); end
    end
  endtask

  task automatic test_zero_full();
    int s, r0, d0, q0, v0;
    d0 = done_cyc.size(); q0 = rd_cyc.size(); v0 = valid_cnt;
    launch(0, s);
    wait_done(d0, 10);
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (done_cyc.size() != d0 + 1) begin nerr++; $display("FAIL zero_done_count got %0d exp 1", done_cyc.size() - d0); end
    if (done_cyc.size() > d0) begin
      nvec++; if (done_cyc[d0] != s + 1) begin nerr++; $display("FAIL zero_done_cycle got %0d exp 1", done_cyc[d0] - s); end
    end
    nvec++; if (rd_cyc.size() != q0) begin nerr++; $display("FAIL zero_rd_count got %0d exp 0", rd_cyc.size() - q0); end
    nvec++; if (valid_cnt != v0) begin nerr++; $display("FAIL zero_valid_cycles got %0d exp 0", valid_cnt - v0); end

    for (int i = 0; i < 32; i++) push(32'h100 + i);
    r0 = rx_data.size(); d0 = done_cyc.size(); q0 = rd_cyc.size();
    launch(32, s);
    wait_done(d0, 100);
    nvec++; if (done_cyc.size() != d0 + 1) begin nerr++; $display("FAIL full_done_count got %0d exp 1", done_cyc.size() - d0); end
    nvec++; if (rd_cyc.size() - q0 != 32) begin nerr++; $display("FAIL full_rd_count got %0d exp 32", rd_cyc.size() - q0); end
    nvec++; if (rx_data.size() - r0 != 32) begin nerr++; $display("FAIL full_beat_count got %0d exp 32", rx_data.size() - r0); end
    for (int i = 0; i < 32 && r0 + i < rx_data.size(); i++) begin
      nvec++; if (rx_data[r0+i] !== 32'h100 + i) begin nerr++; $display("FAIL full_data[%0d] got %h exp %h", i, rx_data[r0+i], 32'h100 + i); end
      nvec++; if (rx_cyc[r0+i] != s + 3 + i) begin nerr++; $display("FAIL full_beat_cycle[%0d] got %0d exp %0d", i, rx_cyc[r0+i] - s, 3 + i); end
      nvec++; if (rx_last[r0+i] != (i == 31)) begin nerr++; $display("FAIL full_last[%0d] got %b exp %b", i, rx_last[r0+i], (i == 31)); end
    end
  endtask

  task automatic test_start_ignored();
    int s, s2, r0, d0, q0;
    for (int i = 0; i < 8; i++) push(32'h50 + i);
    r0 = rx_data.size(); d0 = done_cyc.size(); q0 = rd_cyc.size();
    launch(4, s);
    for (int i = 0; i < 40 && done_cyc.size() == d0; i++) begin
      if (cyc == s + 3) begin start = 1'b1; burst_len = LW'(9); end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    nvec++; if (done_cyc.size() != d0 + 1) begin nerr++; $display("FAIL ign_done_count got %0d exp 1", done_cyc.size() - d0); end
    nvec++; if (rd_cyc.size() - q0 != 4) begin nerr++; $display("FAIL ign_rd_count got %0d exp 4", rd_cyc.size() - q0); end
    nvec++; if (rx_data.size() - r0 != 4) begin nerr++; $display("FAIL ign_beat_count got %0d exp 4", rx_data.size() - r0); end
    if (done_cyc.size() > d0) begin
      nvec++; if (done_cyc[d0] != s + 7) begin nerr++; $display("FAIL ign_done_cycle got %0d exp 7", done_cyc[d0] - s); end
    end
    launch(4, s2);
    wait_done(d0 + 1, 40);
    nvec++; if (done_cyc.size() != d0 + 2) begin nerr++; $display("FAIL ign_second_done got %0d exp 2", done_cyc.size() - d0); end
    nvec++; if (rx_data.size() - r0 != 8) begin nerr++; $display("FAIL ign_total_beats got %0d exp 8", rx_data.size() - r0); end
    for (int i = 0; i < 8 && r0 + i < rx_data.size(); i++) begin
      nvec++; if (rx_data[r0+i] !== 32'h50 + i) begin nerr++; $display("FAIL ign_data[%0d] got %h exp %h", i, rx_data[r0+i], 32'h50 + i); end
    end
    if (done_cyc.size() > d0 + 1) begin
      nvec++; if (done_cyc[d0+1] != s2 + 7) begin nerr++; $display("FAIL ign_second_done_cycle got %0d exp 7", done_cyc[d0+1] - s2); end
    end
  endtask

  task automatic test_reset_mid();
    int s, r0, d0, dr;
    for (int i = 0; i < 8; i++) push(32'h60 + i);
    r0 = rx_data.size(); d0 = done_cyc.size();
    m_ready = 1'b1;
    launch(8, s);
    for (int i = 0; i < 40 && rx_data.size() < r0 + 3; i++) begin
      @(posedge clk); #1;
    end
    nvec++; if (rx_data.size() - r0 != 3) begin nerr++; $display("FAIL rstmid_beats_before got %0d exp 3", rx_data.size() - r0); end
    #1 rst = 1'b1;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_m_valid got %b exp 0", m_valid); end
    nvec++; if (fifo_rd_en !== 1'b0) begin nerr++; $display("FAIL rstmid_rd_en got %b exp 0", fifo_rd_en); end
    nvec++; if (m_last !== 1'b0) begin nerr++; $display("FAIL rstmid_m_last got %b exp 0", m_last); end
    nvec++; if (m_data !== 32'd0) begin nerr++; $display("FAIL rstmid_m_data got %h exp 0", m_data); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (done_cyc.size() != d0) begin nerr++; $display("FAIL rstmid_no_done got %0d exp 0", done_cyc.size() - d0); end
    dr = rx_data.size();
    launch(2, s);
    wait_done(d0, 30);
    nvec++; if (done_cyc.size() != d0 + 1) begin nerr++; $display("FAIL rstmid_next_done got %0d exp 1", done_cyc.size() - d0); end
    nvec++; if (rx_data.size() - dr != 2) begin nerr++; $display("FAIL rstmid_next_count got %0d exp 2", rx_data.size() - dr); end
    if (rx_data.size() - dr >= 2) begin
      nvec++; if (rx_data[dr] !== 32'h65) begin nerr++; $display("FAIL rstmid_next_data0 got %h exp 65", rx_data[dr]); end
      nvec++; if (rx_data[dr+1] !== 32'h66) begin nerr++; $display("FAIL rstmid_next_data1 got %h exp 66", rx_data[dr+1]); end
      nvec++; if (rx_last[dr+1] != 1'b1) begin nerr++; $display("FAIL rstmid_next_last got %b exp 1", rx_last[dr+1]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout cycles %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_starvation();
    test_zero_full();
    test_start_ignored();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
